// File: rtl/arith_arb_pkg.sv
// rtl/arith_arb_pkg.sv - shared types and constants for the arithmetic-unit arbiter
package arith_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OP_WIDTH   = 2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_EXP = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - cyclic first-set search over a request vector starting at ptr
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      grant
);

    // One extra bit so ptr+k never overflows before the modulo wrap.
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/shared_arith_arbiter.sv
// rtl/shared_arith_arbiter.sv - round-robin sharing of one multi-cycle arithmetic unit with watchdog
module shared_arith_arbiter
    import arith_arb_pkg::*;
#(
    parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REQ        = 4,
    parameter  int OP_WIDTH       = DEFAULT_OP_WIDTH,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int GW             = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    output logic [DATA_WIDTH-1:0]          unit_a,
    output logic [DATA_WIDTH-1:0]          unit_b,
    output logic [OP_WIDTH-1:0]            unit_op,
    output logic                           unit_start,
    input  logic                           unit_done,
    input  logic [DATA_WIDTH-1:0]          unit_result,
    output logic [NUM_REQ-1:0]             rsp_done,
    output logic [DATA_WIDTH-1:0]          rsp_result,
    output logic                           rsp_error,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy
);

    localparam int               WD_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0]  WD_MAX    = '1;
    // Abort fires in the WAIT cycle whose increment would reach TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0]  WD_ABORT  = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t           state;
    logic [GW-1:0]        ptr;
    logic [WD_W-1:0]      wdog;

    logic                 pick_found;
    logic [GW-1:0]        pick_id;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [OP_WIDTH-1:0]  sel_op;
    logic [GW-1:0]        ptr_next;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .grant (pick_id)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == GW'(i)) begin
                sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                sel_op = req_op[i*OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    assign ptr_next = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            wdog       <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_op    <= '0;
            unit_start <= 1'b0;
            rsp_done   <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        unit_a     <= sel_a;
                        unit_b     <= sel_b;
                        unit_op    <= sel_op;
                        grant_id   <= pick_id;
                        unit_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Any unit_done here belongs to nothing we issued; it is not looked at.
                    unit_start <= 1'b0;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (unit_done) begin
                        rsp_result <= unit_result;
                        rsp_error  <= 1'b0;
                        rsp_done   <= ONE_HOT0 << grant_id;
                        state      <= RESPOND;
                    end else if (wdog == WD_ABORT) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                        rsp_done   <= ONE_HOT0 << grant_id;
                        state      <= RESPOND;
                    end else if (wdog != WD_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESPOND: begin
                    rsp_done <= '0;
                    ptr      <= ptr_next;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_arith_arbiter.sv
// tb/tb_shared_arith_arbiter.sv - directed self-checking bench for shared_arith_arbiter
module tb_shared_arith_arbiter;
    import arith_arb_pkg::*;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int OW = 2;
    localparam int TO = 8;

    logic               clock;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_a;
    logic [NR*DW-1:0]   req_b;
    logic [NR*OW-1:0]   req_op;
    logic [DW-1:0]      unit_a;
    logic [DW-1:0]      unit_b;
    logic [OW-1:0]      unit_op;
    logic               unit_start;
    logic               unit_done;
    logic [DW-1:0]      unit_result;
    logic [NR-1:0]      rsp_done;
    logic [DW-1:0]      rsp_result;
    logic               rsp_error;
    logic [1:0]         grant_id;
    logic               busy;

    int checks = 0;
    int errors = 0;

    shared_arith_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .OP_WIDTH       (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_op     (unit_op),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .rsp_done    (rsp_done),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in an IDLE cycle with the request already raised; leaves in the next IDLE cycle.
    task automatic run_op(input int id, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [1:0] eop, input logic [31:0] res, input int lat);
        logic [3:0] exp_done;
        exp_done = 4'b0001 << id;
        step();
        chk("start", {31'd0, unit_start}, 32'd1);
        chk("grant", {30'd0, grant_id}, id);
        chk("unit_a", unit_a, ea);
        chk("unit_b", unit_b, eb);
        chk("unit_op", {30'd0, unit_op}, {30'd0, eop});
        chk("busy_on", {31'd0, busy}, 32'd1);
        for (int s = 0; s < lat; s++) begin
            step();
            if (s == 0) chk("start_low", {31'd0, unit_start}, 32'd0);
        end
        unit_done   = 1'b1;
        unit_result = res;
        step();
        unit_done   = 1'b0;
        chk("rsp_done", {28'd0, rsp_done}, {28'd0, exp_done});
        chk("rsp_result", rsp_result, res);
        chk("rsp_error", {31'd0, rsp_error}, 32'd0);
        req_valid[id] = 1'b0;
        step();
        chk("rsp_done_clr", {28'd0, rsp_done}, 32'd0);
        chk("busy_off", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        unit_done = 1'b0;
        unit_result = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 32'h1000_0000 + i;
            req_b[i*DW +: DW] = 32'h2000_0000 + i;
            req_op[i*OW +: OW] = 2'(i);
        end
        step();
        step();
        chk("rst_outputs", {unit_a | unit_b, 28'd0, rsp_done} , 64'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_misc", {26'd0, unit_op, unit_start, rsp_error, grant_id[0], busy}, 32'd0);
        reset = 1'b0;

        // single request, L=3
        req_a[1*DW +: DW] = 32'h3F80_0000;
        req_b[1*DW +: DW] = 32'h4000_0000;
        req_op[1*OW +: OW] = OP_ADD;
        req_valid = 4'b0010;
        run_op(1, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 3);
        chk("hold_result", rsp_result, 32'h4040_0000);

        // all four from reset: order 0,1,2,3
        req_a[1*DW +: DW] = 32'h1000_0001;
        req_b[1*DW +: DW] = 32'h2000_0001;
        req_op[1*OW +: OW] = OP_MUL;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b1111;
        run_op(0, 32'h1000_0000, 32'h2000_0000, OP_ADD, 32'hA000_0000, 2);
        run_op(1, 32'h1000_0001, 32'h2000_0001, OP_MUL, 32'hA000_0001, 1);
        run_op(2, 32'h1000_0002, 32'h2000_0002, OP_EXP, 32'hA000_0002, 4);
        run_op(3, 32'h1000_0003, 32'h2000_0003, OP_DIV, 32'hA000_0003, 2);
        req_valid = 4'b1001;
        run_op(0, 32'h1000_0000, 32'h2000_0000, OP_ADD, 32'hB000_0000, 1);
        run_op(3, 32'h1000_0003, 32'h2000_0003, OP_DIV, 32'hB000_0003, 1);

        // timeout: rsp_done 8 cycles after ISSUE
        req_valid = 4'b0100;
        step();
        chk("to_start", {31'd0, unit_start}, 32'd1);
        chk("to_grant", {30'd0, grant_id}, 32'd2);
        for (int s = 0; s < 7; s++) step();
        chk("to_not_early", {28'd0, rsp_done}, 32'd0);
        step();
        chk("to_done", {28'd0, rsp_done}, 32'h4);
        chk("to_error", {31'd0, rsp_error}, 32'd1);
        chk("to_result", rsp_result, 32'd0);
        req_valid = 4'b0000;
        step();
        chk("to_idle", {31'd0, busy}, 32'd0);

        // done in final watchdog cycle wins
        req_valid = 4'b0010;
        run_op(1, 32'h1000_0001, 32'h2000_0001, OP_MUL, 32'h1234_5678, 7);

        // spurious done during ISSUE, real done at L=2
        req_valid = 4'b0100;
        step();
        chk("sp_grant", {30'd0, grant_id}, 32'd2);
        unit_done = 1'b1;
        unit_result = 32'hDEAD_BEEF;
        step();
        unit_done = 1'b0;
        chk("sp_ignored", {28'd0, rsp_done}, 32'd0);
        step();
        unit_done = 1'b1;
        unit_result = 32'h0BAD_F00D;
        step();
        unit_done = 1'b0;
        chk("sp_done", {28'd0, rsp_done}, 32'h4);
        chk("sp_result", rsp_result, 32'h0BAD_F00D);
        req_valid = 4'b0000;
        step();
        chk("sp_single", {28'd0, rsp_done}, 32'd0);

        // reset mid-WAIT, stray done afterwards
        req_valid = 4'b1000;
        step();
        chk("rw_grant", {30'd0, grant_id}, 32'd3);
        step();
        reset = 1'b1;
        req_valid = 4'b0000;
        step();
        reset = 1'b0;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_unit_a", unit_a, 32'd0);
        chk("rw_result", rsp_result, 32'd0);
        chk("rw_misc", {28'd0, unit_start, rsp_error, grant_id}, 32'd0);
        step();
        unit_done = 1'b1;
        unit_result = 32'h0000_FFFF;
        step();
        unit_done = 1'b0;
        chk("rw_no_done", {28'd0, rsp_done}, 32'd0);
        chk("rw_idle", {31'd0, busy}, 32'd0);
        req_valid = 4'b1001;
        run_op(0, 32'h1000_0000, 32'h2000_0000, OP_ADD, 32'hC000_0000, 1);
        req_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
